game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// -----------------------------------------------------------------------------
// game_sequencer
//   Top-level game flow controller for a breakout-style game. Walks the game
//   through IDLE -> SERVE -> PLAY -> WIN/LOSE, tracks lives and score, and
//   issues the field-reset and ball-launch pulses to the playfield logic.
//
// Ports
//   clk          in   system clock, all state updates on its rising edge
//   rst          in   asynchronous reset, active-low
//   start        in   player start request (level)
//   vsync        in   VGA vertical sync, active-low; falling edge = new frame
//   block_hit    in   one-cycle pulse per destroyed block
//   miss         in   one-cycle pulse when the ball passes below the paddle
//   alive        in   block alive mask, 1 = block present
//   state        out  IDLE=0, SERVE=1, PLAY=2, WIN=3, LOSE=4
//   field_reset  out  one-cycle pulse: restore blocks, recentre paddle
//   launch       out  one-cycle pulse: release ball from paddle
//   ball_run     out  high only in PLAY
//   lives        out  remaining lives
//   score        out  blocks destroyed this game (saturates at 255)
//   win, lose    out  high in WIN / LOSE
// -----------------------------------------------------------------------------
module game_sequencer #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned NUM_BLOCKS   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  vsync,
  input  logic                  block_hit,
  input  logic                  miss,
  input  logic [NUM_BLOCKS-1:0] alive,
  output logic [2:0]            state,
  output logic                  field_reset,
  output logic                  launch,
  output logic                  ball_run,
  output logic [1:0]            lives,
  output logic [7:0]            score,
  output logic                  win,
  output logic                  lose
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [7:0]  score_q, score_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        field_reset_q, field_reset_d;
  logic        launch_q, launch_d;
  logic        ball_run_q, ball_run_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic        vsync_q;
  logic        start_q;

  logic        frame_tick;
  logic        start_edge;
  logic        field_clear;

  // Falling edge of vsync marks the start of a new frame; a held start
  // request yields a single edge because start_q follows it.
  assign frame_tick  = vsync_q & ~vsync;
  assign start_edge  = start & ~start_q;
  assign field_clear = ~|alive;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d       = state_q;
    lives_d       = lives_q;
    score_d       = score_q;
    frame_cnt_d   = frame_cnt_q;
    field_reset_d = 1'b0;
    launch_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d       = S_SERVE;
          lives_d       = 2'(LIVES);
          score_d       = '0;
          frame_cnt_d   = '0;
          field_reset_d = 1'b1;
        end
      end

      // Hits and misses are ignored while the ball sits on the paddle.
      S_SERVE: begin
        if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
          if (frame_cnt_q == 8'(SERVE_FRAMES - 1)) begin
            state_d  = S_PLAY;
            launch_d = 1'b1;
          end
        end
      end

      S_PLAY: begin
        // Scoring applies even when the same cycle also ends the rally.
        if (block_hit && (score_q != 8'hFF)) begin
          score_d = score_q + 8'd1;
        end
        // A cleared field wins even if the ball was missed in that cycle.
        if (field_clear) begin
          state_d = S_WIN;
        end else if (miss) begin
          if (lives_q > 2'd1) begin
            lives_d     = lives_q - 2'd1;
            frame_cnt_d = '0;
            state_d     = S_SERVE;
          end else begin
            lives_d = '0;
            state_d = S_LOSE;
          end
        end
      end

      S_WIN, S_LOSE: begin
        if (start_edge) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Level outputs are registered from the next state so they line up
    // with the state register.
    ball_run_d = (state_d == S_PLAY);
    win_d      = (state_d == S_WIN);
    lose_d     = (state_d == S_LOSE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      lives_q       <= '0;
      score_q       <= '0;
      frame_cnt_q   <= '0;
      field_reset_q <= 1'b0;
      launch_q      <= 1'b0;
      ball_run_q    <= 1'b0;
      win_q         <= 1'b0;
      lose_q        <= 1'b0;
      vsync_q       <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      score_q       <= score_d;
      frame_cnt_q   <= frame_cnt_d;
      field_reset_q <= field_reset_d;
      launch_q      <= launch_d;
      ball_run_q    <= ball_run_d;
      win_q         <= win_d;
      lose_q        <= lose_d;
      vsync_q       <= vsync;
      start_q       <= start;
    end
  end

  assign state       = state_q;
  assign field_reset = field_reset_q;
  assign launch      = launch_q;
  assign ball_run    = ball_run_q;
  assign lives       = lives_q;
  assign score       = score_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_game_sequencer.sv
// -----------------------------------------------------------------------------
// tb_game_sequencer
//   Directed testbench for game_sequencer. Stimulus pushes the expected output
//   snapshot for each state change into a queue; a monitor pops and compares
//   whenever the DUT's state output changes. Steady-state values are checked
//   directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_game_sequencer;

  localparam int NB = 15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_WIN   = 3'd3;
  localparam logic [2:0] ST_LOSE  = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lv;
    logic [7:0] sc;
    logic       fr;
    logic       la;
    logic       br;
    logic       w;
    logic       l;
  } snap_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          vsync;
  logic          block_hit;
  logic          miss;
  logic [NB-1:0] alive;
  logic [2:0]    state;
  logic          field_reset;
  logic          launch;
  logic          ball_run;
  logic [1:0]    lives;
  logic [7:0]    score;
  logic          win;
  logic          lose;

  int    errors = 0;
  int    checks = 0;
  int    fr_count = 0;
  int    la_count = 0;
  snap_t exp_q[$];

  game_sequencer #(.LIVES(3), .SERVE_FRAMES(60), .NUM_BLOCKS(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .vsync       (vsync),
    .block_hit   (block_hit),
    .miss        (miss),
    .alive       (alive),
    .state       (state),
    .field_reset (field_reset),
    .launch      (launch),
    .ball_run    (ball_run),
    .lives       (lives),
    .score       (score),
    .win         (win),
    .lose        (lose)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic snap_t cur();
    return {state, lives, score, field_reset, launch, ball_run, win, lose};
  endfunction

  function automatic snap_t mk(input logic [2:0] st, input logic [1:0] lv, input logic [7:0] sc,
                               input logic fr, input logic la, input logic br,
                               input logic w, input logic l);
    return {st, lv, sc, fr, la, br, w, l};
  endfunction

  // Monitor: compare one expected snapshot per observed state change, and
  // make sure the pulse outputs never stay high two cycles in a row.
  logic [2:0] prev_state = ST_IDLE;
  logic       prev_fr    = 1'b0;
  logic       prev_la    = 1'b0;
  always @(negedge clk) begin
    if (state !== prev_state) begin
      if (exp_q.size() == 0) begin
        check("unexpected_transition", {29'd0, state}, {29'd0, prev_state});
      end else begin
        check("transition", 32'(cur()), 32'(exp_q.pop_front()));
      end
      prev_state = state;
    end
    if (field_reset === 1'b1) begin
      fr_count++;
      check("field_reset_one_cycle", {31'd0, prev_fr}, 32'd0);
    end
    if (launch === 1'b1) begin
      la_count++;
      check("launch_one_cycle", {31'd0, prev_la}, 32'd0);
    end
    prev_fr = field_reset;
    prev_la = launch;
  end

  // Inputs change 2 ns after the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic tick();
    vsync = 1'b0; cyc(1);
    vsync = 1'b1; cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic start_press();
    start = 1'b1; cyc(5);
    start = 1'b0; cyc(1);
  endtask

  task automatic pulse_hit();
    block_hit = 1'b1; cyc(1);
    block_hit = 1'b0; cyc(1);
  endtask

  task automatic pulse_miss();
    miss = 1'b1; cyc(1);
    miss = 1'b0; cyc(1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; vsync = 1'b1; block_hit = 1'b0; miss = 1'b0;
    alive = '1;
    rst   = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("reset_outputs", 32'(cur()), 32'd0);
    cyc(3);
    rst = 1'b1;
    cyc(3);
    check("idle_after_release", 32'(cur()), 32'd0);

    // Game 1: held start gives one field_reset and enters SERVE.
    exp_q.push_back(mk(ST_SERVE, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start_press();
    check("serve_entry_fr_count", fr_count, 32'd1);
    check("serve_entry_snapshot", 32'(cur()), 32'(mk(ST_SERVE, 2'd3, 8'd0, 0, 0, 0, 0, 0)));

    // Hits and misses during SERVE have no effect.
    pulse_hit();
    pulse_miss();
    ticks(59);
    check("serve_after_59_ticks", 32'(cur()), 32'(mk(ST_SERVE, 2'd3, 8'd0, 0, 0, 0, 0, 0)));

    exp_q.push_back(mk(ST_PLAY, 2'd3, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tick();
    check("launch_count_1", la_count, 32'd1);

    repeat (10) pulse_hit();
    check("score_after_10", {24'd0, score}, 32'd10);

    // Hit and miss together: score counts and a life is lost.
    exp_q.push_back(mk(ST_SERVE, 2'd2, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    block_hit = 1'b1; miss = 1'b1; cyc(1);
    block_hit = 1'b0; miss = 1'b0; cyc(1);

    exp_q.push_back(mk(ST_PLAY, 2'd2, 8'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(60);

    repeat (300) pulse_hit();
    check("score_saturated", 32'(cur()), 32'(mk(ST_PLAY, 2'd2, 8'd255, 0, 0, 1, 0, 0)));

    exp_q.push_back(mk(ST_SERVE, 2'd1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    pulse_miss();
    exp_q.push_back(mk(ST_PLAY, 2'd1, 8'd255, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(60);
    exp_q.push_back(mk(ST_LOSE, 2'd0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    pulse_miss();

    // LOSE holds against everything but start.
    pulse_hit();
    pulse_miss();
    ticks(3);
    check("lose_hold", 32'(cur()), 32'(mk(ST_LOSE, 2'd0, 8'd255, 0, 0, 0, 0, 1)));

    exp_q.push_back(mk(ST_IDLE, 2'd0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    start_press();

    // Game 2: field cleared in the same cycle as a miss -> WIN, lives kept.
    exp_q.push_back(mk(ST_SERVE, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start_press();
    exp_q.push_back(mk(ST_PLAY, 2'd3, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    ticks(60);
    exp_q.push_back(mk(ST_WIN, 2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    alive = '0; miss = 1'b1; cyc(1);
    miss = 1'b0; cyc(1);
    check("win_hold", 32'(cur()), 32'(mk(ST_WIN, 2'd3, 8'd0, 0, 0, 0, 1, 0)));
    alive = '1;
    exp_q.push_back(mk(ST_IDLE, 2'd3, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    start_press();

    // Game 3: reset mid-SERVE acts without a clock edge.
    exp_q.push_back(mk(ST_SERVE, 2'd3, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    start_press();
    ticks(30);
    exp_q.push_back(mk(ST_IDLE, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    check("async_reset_mid_serve", 32'(cur()), 32'd0);
    cyc(3);
    rst = 1'b1;
    cyc(10);
    check("idle_without_start", 32'(cur()), 32'd0);

    cyc(2);
    check("total_field_resets", fr_count, 32'd3);
    check("total_launches", la_count, 32'd4);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
